// File: rtl/cnn_stage_sequencer_pkg.sv
// rtl/cnn_stage_sequencer_pkg.sv - shared types and helpers for the CNN stage sequencer
// Purpose: state enum, width defaults and the budget-slice helper used by the
// sequencer and its stage timer.
package cnn_stage_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam int DEFAULT_CNT_WIDTH = 24;
  localparam int MAX_STAGES        = 16;
  localparam int MAX_CNT_WIDTH     = 32;
  localparam int MAX_FLAT_WIDTH    = MAX_STAGES * MAX_CNT_WIDTH;

  // Width of a stage index: clog2 of the stage count, never narrower than 1.
  function automatic int stage_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Pull stage k's budget out of a flat vector of width-bit fields.
  // The flat vector is zero-extended to the maximum size by the caller.
  function automatic logic [MAX_CNT_WIDTH-1:0] budget_slice(
    input logic [MAX_FLAT_WIDTH-1:0] flat,
    input int                        width,
    input int                        k
  );
    logic [MAX_FLAT_WIDTH-1:0] shifted;
    logic [MAX_CNT_WIDTH-1:0]  mask;
    shifted = flat >> (k * width);
    mask    = (width >= MAX_CNT_WIDTH) ? '1
            : ((MAX_CNT_WIDTH'(1) << width) - MAX_CNT_WIDTH'(1));
    return MAX_CNT_WIDTH'(shifted) & mask;
  endfunction

endpackage

// File: rtl/cnn_stage_sequencer_stage_timer.sv
// rtl/cnn_stage_sequencer_stage_timer.sv - saturating per-stage cycle counter with budget expiry
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear        synchronous counter clear (wins over enable)
//   enable       count this cycle
//   budget       cycle budget of the running stage, 0 = unlimited
//   cnt          cycles elapsed, saturates at all-ones
//   expire       budget != 0 and this is the last budgeted cycle
module stage_timer
  import cnn_stage_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] budget,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // Expiry fires while cnt holds budget-1, so a stage with no done strobe
  // is active for exactly budget cycles.
  assign expire = (budget != '0) && (cnt == budget - CNT_WIDTH'(1));

endmodule

// File: rtl/cnn_stage_sequencer.sv
// rtl/cnn_stage_sequencer.sv - start/busy/done run controller releasing per-stage resets in order
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start_i        job start, sampled only in IDLE
//   abort_i        cancel the running job
//   budget_i       per-stage cycle budgets, stage k at [k*CNT_WIDTH +: CNT_WIDTH], 0 = unlimited
//   stage_done_i   per-stage completion strobes (only the running stage's bit is looked at)
//   stage_rst_o    registered active-high reset to each stage
//   busy_o         job in progress
//   done_o         one-cycle pulse on job completion
//   aborted_o      one-cycle pulse on job abort
//   timeout_o      sticky per-stage budget-expiry flags, cleared on start
//   cur_stage_o    index of the running stage
//   cycle_cnt_o    cycles elapsed in the current stage
module cnn_stage_sequencer
  import cnn_stage_sequencer_pkg::*;
#(
  parameter int   NUM_STAGES = 3,
  parameter int   CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  parameter bit   KEEP_PREV  = 1'b1,
  localparam int  SW         = stage_idx_width(NUM_STAGES)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0] budget_i,
  input  logic [NUM_STAGES-1:0]           stage_done_i,
  output logic [NUM_STAGES-1:0]           stage_rst_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            aborted_o,
  output logic [NUM_STAGES-1:0]           timeout_o,
  output logic [SW-1:0]                   cur_stage_o,
  output logic [CNT_WIDTH-1:0]            cycle_cnt_o
);

  seq_state_t                      state, state_next;
  logic [SW-1:0]                   stage_q, stage_next;
  logic [NUM_STAGES-1:0]           rst_q, rst_next;
  logic [NUM_STAGES-1:0]           timeout_q, timeout_next;
  logic                            done_q, done_next;
  logic                            aborted_q, aborted_next;
  logic [NUM_STAGES*CNT_WIDTH-1:0] budget_q;
  logic                            latch;
  logic                            clear;
  logic                            done_k;
  logic                            expire;
  logic                            last;
  logic [CNT_WIDTH-1:0]            cnt;
  logic [MAX_FLAT_WIDTH-1:0]       budget_flat;
  logic [MAX_CNT_WIDTH-1:0]        budget_sel_full;
  logic [CNT_WIDTH-1:0]            budget_sel;
  logic                            unused_budget_bits;

  // Budget of the running stage, taken from the copy latched at start so
  // that budget_i changes during a job have no effect.
  always_comb begin
    budget_flat = '0;
    budget_flat[NUM_STAGES*CNT_WIDTH-1:0] = budget_q;
  end

  assign budget_sel_full    = budget_slice(budget_flat, CNT_WIDTH, int'(stage_q));
  assign budget_sel         = budget_sel_full[CNT_WIDTH-1:0];
  assign unused_budget_bits = ^budget_sel_full;

  stage_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (state == RUN),
    .budget (budget_sel),
    .cnt    (cnt),
    .expire (expire)
  );

  assign last = (stage_q == SW'(NUM_STAGES - 1));

  always_comb begin
    state_next   = state;
    stage_next   = stage_q;
    rst_next     = rst_q;
    timeout_next = timeout_q;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    latch        = 1'b0;
    clear        = 1'b0;
    done_k       = 1'b0;

    for (int s = 0; s < NUM_STAGES; s++) begin
      if (stage_q == SW'(s)) done_k = stage_done_i[s];
    end

    case (state)
      IDLE: begin
        clear = 1'b1;
        if (start_i && !abort_i) begin
          state_next   = RUN;
          stage_next   = '0;
          rst_next     = '1;
          rst_next[0]  = 1'b0;
          timeout_next = '0;
          latch        = 1'b1;
        end
      end

      RUN: begin
        if (abort_i) begin
          state_next   = IDLE;
          stage_next   = '0;
          rst_next     = '1;
          aborted_next = 1'b1;
          clear        = 1'b1;
        end else if (done_k || expire) begin
          clear = 1'b1;
          // A done strobe on the expiry edge wins: no timeout recorded.
          if (expire && !done_k) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
              if (stage_q == SW'(s)) timeout_next[s] = 1'b1;
            end
          end
          if (last) begin
            state_next = IDLE;
            stage_next = '0;
            rst_next   = '1;
            done_next  = 1'b1;
          end else begin
            stage_next = stage_q + SW'(1);
            for (int s = 0; s < NUM_STAGES; s++) begin
              if (!KEEP_PREV && (stage_q == SW'(s))) rst_next[s] = 1'b1;
              if (stage_next == SW'(s))              rst_next[s] = 1'b0;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
        rst_next   = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stage_q   <= '0;
      rst_q     <= '1;
      timeout_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      budget_q  <= '0;
    end else begin
      state     <= state_next;
      stage_q   <= stage_next;
      rst_q     <= rst_next;
      timeout_q <= timeout_next;
      done_q    <= done_next;
      aborted_q <= aborted_next;
      if (latch) budget_q <= budget_i;
    end
  end

  assign stage_rst_o = rst_q;
  assign busy_o      = (state == RUN);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign timeout_o   = timeout_q;
  assign cur_stage_o = stage_q;
  assign cycle_cnt_o = cnt;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// tb/tb_cnn_stage_sequencer.sv - self-checking bench for cnn_stage_sequencer
module tb_cnn_stage_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [71:0] budget;
  logic [2:0]  stage_done;

  logic [2:0]  rst_a, rst_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        ab_a, ab_b;
  logic [2:0]  to_a, to_b;
  logic [1:0]  stg_a, stg_b;
  logic [23:0] cnt_a, cnt_b;

  cnn_stage_sequencer #(.NUM_STAGES(3), .CNT_WIDTH(24), .KEEP_PREV(1'b1)) dut (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .budget_i(budget),
    .stage_done_i(stage_done), .stage_rst_o(rst_a), .busy_o(busy_a), .done_o(done_a),
    .aborted_o(ab_a), .timeout_o(to_a), .cur_stage_o(stg_a), .cycle_cnt_o(cnt_a)
  );

  cnn_stage_sequencer #(.NUM_STAGES(3), .CNT_WIDTH(24), .KEEP_PREV(1'b0)) dut_kp0 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .budget_i(budget),
    .stage_done_i(stage_done), .stage_rst_o(rst_b), .busy_o(busy_b), .done_o(done_b),
    .aborted_o(ab_b), .timeout_o(to_b), .cur_stage_o(stg_b), .cycle_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       is_abort;
    logic [2:0] timeout;
    int         at_cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          en;
    logic [2:0]  rst;
    logic        busy;
    logic        done;
    logic [1:0]  stage;
    logic [23:0] cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any job-end pulse seen there.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (done_a || ab_a) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b aborted=%0b expected none (cyc %0d)",
                 done_a, ab_a, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_kind", 64'({done_a, ab_a}), 64'(e.is_abort ? 2'b01 : 2'b10));
        chk("pulse_timeout", 64'(to_a), 64'(e.timeout));
        chk("pulse_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
  endtask

  task automatic expect_end(input logic is_abort, input logic [2:0] tmo, input int end_edge);
    sb_t e;
    e.is_abort = is_abort;
    e.timeout  = tmo;
    e.at_cyc   = cyc + 1 + end_edge;
    sb_q.push_back(e);
  endtask

  function automatic logic [71:0] pack3(input int b2, input int b1, input int b0);
    return {24'(b2), 24'(b1), 24'(b0)};
  endfunction

  initial begin
    int ti;
    tbl[0] = '{0,  3'b110, 1'b1, 1'b0, 2'd0, 24'd0};
    tbl[1] = '{4,  3'b110, 1'b1, 1'b0, 2'd0, 24'd4};
    tbl[2] = '{5,  3'b100, 1'b1, 1'b0, 2'd1, 24'd0};
    tbl[3] = '{7,  3'b100, 1'b1, 1'b0, 2'd1, 24'd2};
    tbl[4] = '{8,  3'b000, 1'b1, 1'b0, 2'd2, 24'd0};
    tbl[5] = '{11, 3'b000, 1'b1, 1'b0, 2'd2, 24'd3};
    tbl[6] = '{12, 3'b111, 1'b0, 1'b1, 2'd0, 24'd0};
    tbl[7] = '{13, 3'b111, 1'b0, 1'b0, 2'd0, 24'd0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; budget = '0; stage_done = '0;
    tick();
    chk("rst_rst",   64'(rst_a),  64'(3'b111));
    chk("rst_busy",  64'(busy_a), 64'(0));
    chk("rst_done",  64'(done_a), 64'(0));
    chk("rst_abort", 64'(ab_a),   64'(0));
    chk("rst_tmo",   64'(to_a),   64'(0));
    chk("rst_stage", 64'(stg_a),  64'(0));
    chk("rst_cnt",   64'(cnt_a),  64'(0));
    reset = 1'b0;
    tick();

    // Budgets stage2..0 = 4,3,5, no done strobes: all stages time out.
    budget = pack3(4, 3, 5); start = 1'b1;
    expect_end(1'b0, 3'b111, 12);
    ti = 0;
    for (int e = 0; e <= 13; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      while (ti < 8 && tbl[ti].en == e) begin
        chk($sformatf("t1_rst_e%0d", e),   64'(rst_a),  64'(tbl[ti].rst));
        chk($sformatf("t1_busy_e%0d", e),  64'(busy_a), 64'(tbl[ti].busy));
        chk($sformatf("t1_done_e%0d", e),  64'(done_a), 64'(tbl[ti].done));
        chk($sformatf("t1_stage_e%0d", e), 64'(stg_a),  64'(tbl[ti].stage));
        chk($sformatf("t1_cnt_e%0d", e),   64'(cnt_a),  64'(tbl[ti].cnt));
        ti++;
      end
      if (e == 12) chk("t1_timeout", 64'(to_a), 64'(3'b111));
    end

    // Done strobe on stage 1; a stray strobe for stage 2 during stage 0 is ignored.
    budget = pack3(4, 3, 5); start = 1'b1;
    expect_end(1'b0, 3'b101, 11);
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      if (e == 2) stage_done = 3'b100;
      if (e == 3) begin
        stage_done = 3'b000;
        chk("t2_stage_e3", 64'(stg_a), 64'(0));
        chk("t2_cnt_e3",   64'(cnt_a), 64'(3));
      end
      if (e == 5) chk("t2_rst_e5", 64'(rst_a), 64'(3'b100));
      if (e == 6) stage_done = 3'b010;
      if (e == 7) begin
        stage_done = 3'b000;
        chk("t2_rst_e7",   64'(rst_a), 64'(3'b000));
        chk("t2_stage_e7", 64'(stg_a), 64'(2));
      end
      if (e == 11) chk("t2_timeout", 64'(to_a), 64'(3'b101));
      if (e == 12) chk("t2_busy_e12", 64'(busy_a), 64'(0));
    end

    // KEEP_PREV=0: one stage out of reset at a time.
    budget = pack3(2, 2, 2); start = 1'b1;
    expect_end(1'b0, 3'b111, 6);
    for (int e = 0; e <= 6; e++) begin
      logic [2:0] want;
      tick();
      if (e == 0) start = 1'b0;
      want = (e < 2) ? 3'b110 : (e < 4) ? 3'b101 : (e < 6) ? 3'b011 : 3'b111;
      chk($sformatf("kp0_rst_e%0d", e), 64'(rst_b), 64'(want));
      if (e == 4) chk("kp1_rst_e4", 64'(rst_a), 64'(3'b000));
    end

    // Unlimited budgets: stage 0 holds until abort; start clears old timeouts.
    budget = pack3(0, 0, 0); start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_tmo_cleared", 64'(to_a), 64'(0));
    for (int e = 1; e <= 1000; e++) tick();
    chk("t4_cnt_1000", 64'(cnt_a),  64'(1000));
    chk("t4_stage",    64'(stg_a),  64'(0));
    chk("t4_rst",      64'(rst_a),  64'(3'b110));
    chk("t4_busy",     64'(busy_a), 64'(1));
    abort = 1'b1;
    expect_end(1'b1, 3'b000, 0);
    tick();
    abort = 1'b0;
    chk("t4_ab_pulse", 64'(ab_a),   64'(1));
    chk("t4_ab_rst",   64'(rst_a),  64'(3'b111));
    chk("t4_ab_busy",  64'(busy_a), 64'(0));
    tick();
    chk("t4_ab_single", 64'(ab_a), 64'(0));

    // Budget of 1 on stage 0, then abort in unlimited stage 1 keeps the timeout.
    budget = pack3(0, 0, 1); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t4b_stage", 64'(stg_a), 64'(1));
    chk("t4b_tmo",   64'(to_a),  64'(3'b001));
    tick();
    tick();
    abort = 1'b1;
    expect_end(1'b1, 3'b001, 0);
    tick();
    abort = 1'b0;
    chk("t4b_tmo_kept", 64'(to_a), 64'(3'b001));

    // Done coinciding with stage 0 expiry; start during RUN ignored.
    budget = pack3(4, 3, 5); start = 1'b1;
    expect_end(1'b0, 3'b110, 12);
    for (int e = 0; e <= 13; e++) begin
      tick();
      if (e == 0) start = 1'b0;
      if (e == 4) stage_done = 3'b001;
      if (e == 5) begin
        stage_done = 3'b000;
        chk("t5_stage_e5", 64'(stg_a), 64'(1));
        chk("t5_tmo0_e5",  64'(to_a),  64'(3'b000));
      end
      if (e == 6) start = 1'b1;
      if (e == 7) begin
        start = 1'b0;
        chk("t5_stage_e7", 64'(stg_a), 64'(1));
        chk("t5_cnt_e7",   64'(cnt_a), 64'(2));
      end
      if (e == 13) chk("t5_busy_e13", 64'(busy_a), 64'(0));
    end

    // Asynchronous reset mid stage 1.
    budget = pack3(4, 3, 5); start = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 0) start = 1'b0;
    end
    chk("t6_pre_stage", 64'(stg_a), 64'(1));
    chk("t6_pre_tmo",   64'(to_a),  64'(3'b001));
    #2 reset = 1'b1;
    #1;
    chk("t6_async_rst",   64'(rst_a),  64'(3'b111));
    chk("t6_async_busy",  64'(busy_a), 64'(0));
    chk("t6_async_stage", 64'(stg_a),  64'(0));
    chk("t6_async_cnt",   64'(cnt_a),  64'(0));
    chk("t6_async_tmo",   64'(to_a),   64'(0));
    tick();
    reset = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    chk("t6_sa_busy", 64'(busy_a), 64'(0));
    chk("t6_sa_rst",  64'(rst_a),  64'(3'b111));
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t6_sa_busy2", 64'(busy_a), 64'(0));
    tick();

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_stage_sequencer.md
Name: cnn_stage_sequencer

Overview:
Parametrised run controller for the CNN/ANN inference chain. It replaces hard-coded free-running cycle counting with a start/busy/done job handshake. Per-stage resets are released one stage at a time. Each stage ends on its own done strobe or on a runtime-loaded cycle budget, whichever comes first. Budget expiries are flagged as timeouts, and an abort path is provided. The block sits at the top level, driving the reset inputs of the conv chain, the format converter and the fully-connected stage.

Parameters:
NUM_STAGES, 3, number of sequenced stages (1..16)
CNT_WIDTH, 24, width of each stage budget and of the cycle counter
KEEP_PREV, 1, 1 = completed stages stay out of reset until job end; 0 = a stage returns to reset when the next stage starts

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start_i  input  1  job start request, sampled only in IDLE
abort_i  input  1  cancel running job
budget_i  input  NUM_STAGES*CNT_WIDTH  per-stage cycle budgets, stage k at bits [k*CNT_WIDTH +: CNT_WIDTH]; 0 = unlimited
stage_done_i  input  NUM_STAGES  per-stage completion strobes
stage_rst_o  output  NUM_STAGES  active-high reset to each stage
busy_o  output  1  job in progress
done_o  output  1  one-cycle pulse, job completed
aborted_o  output  1  one-cycle pulse, job aborted
timeout_o  output  NUM_STAGES  sticky per-stage budget-expiry flags
cur_stage_o  output  clog2(NUM_STAGES) max 1  index of the running stage
cycle_cnt_o  output  CNT_WIDTH  cycles elapsed in the current stage

Behaviour:
- Async reset state: state IDLE; stage_rst_o all 1; busy_o 0; done_o 0; aborted_o 0; timeout_o 0; cur_stage_o 0; cycle_cnt_o 0; latched budgets 0.
- States: IDLE and RUN. done_o and aborted_o are registered pulses, not states.
- IDLE, start_i=1, abort_i=0 at edge E0:
  - latch budget_i;
  - clear timeout_o;
  - go to RUN with stage 0 and cnt 0;
  - after E0: busy_o=1 and stage_rst_o[0]=0.
- IDLE, start_i and abort_i both 1: no action, no pulse.
- RUN, stage k: cnt increments every cycle and saturates at all-ones. Stage k completes at an edge where either condition holds:
  - stage_done_i[k]=1;
  - budget[k]!=0 and cnt==budget[k]-1.
  - With no done strobe, stage k is therefore active exactly budget[k] cycles.
- If the budget expires with stage_done_i[k]=0, set timeout_o[k].
- If done and expiry coincide, it counts as done: no timeout.
- stage_done_i bits other than [k] are ignored.
- Advance from k<NUM_STAGES-1:
  - cur_stage_o=k+1, cnt=0, stage_rst_o[k+1]=0;
  - if KEEP_PREV=0, stage_rst_o[k]=1.
- Completion of the last stage:
  - go to IDLE;
  - all stage_rst_o=1, busy_o=0, cur_stage_o=0, cnt=0;
  - done_o=1 for exactly the following cycle.
- RUN, abort_i=1 (priority over done and expiry):
  - go to IDLE next edge with all resets reasserted;
  - aborted_o pulses one cycle; no done_o;
  - timeout_o keeps its value.
- start_i while RUN is ignored.
- A budget of 0 with no done strobe holds the stage forever; only abort or reset exits.
- Reset asserted mid-job forces the reset values immediately, asynchronously.
- Budgets changing on budget_i during RUN have no effect.
- Every stage_rst_o bit is a flop output (glitch-free, usable as a downstream async reset).

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN);
  - a function returning the stage-index width (clog2 with minimum 1);
  - default CNT_WIDTH;
  - a function extracting the budget slice for stage k.
- One sub-module, stage_timer. Inputs: clear, enable, budget. Outputs: the saturating counter and an expire flag, computed as budget!=0 && cnt==budget-1.
- The sequencer instantiates one stage_timer and muxes in the current stage's budget.

Test Plan:
- NUM_STAGES=3, KEEP_PREV=1, budgets {4,3,5} (stage2..0), no done strobes, start at E0:
  - stage_rst_o goes 110 after E0, 100 after E5, 000 after E8;
  - done_o high in the cycle after E12; busy_o low after E12;
  - timeout_o=111.
- Same budgets, stage_done_i[1] pulsed in the cycle after E6: stage 2 starts after E7; done_o follows E11; timeout_o=101.
- KEEP_PREV=0, budgets {2,2,2}: exactly one stage_rst_o bit is 0 at any time during RUN; the order is 110, 101, 011.
- Budget {0,0,0}:
  - holds stage 0 for 1000 cycles with cycle_cnt_o=1000;
  - abort_i at cycle 1000 gives aborted_o pulse, stage_rst_o=111, and no done_o;
  - a new start clears timeout_o.
- Done strobe coinciding with the budget-expiry edge in stage 0: the advance happens with timeout_o[0]=0. A start_i pulse during RUN is ignored, and cycle_cnt_o is unaffected.
- Async reset asserted mid-stage-1 between clock edges: outputs go to reset values immediately. After release, start_i=1 together with abort_i=1 in IDLE produces no busy_o.
